// File: rtl/circle_engine_if.sv
// rtl/circle_engine_if.sv - request/response and pixel-stream bundle for circle_engine
interface circle_engine_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int R_W = 8
);
    logic           start;
    logic [X_W-1:0] centre_x;
    logic [Y_W-1:0] centre_y;
    logic [R_W-1:0] radius;
    logic [2:0]     colour;
    logic [7:0]     octant_mask;
    logic           done;
    logic [X_W-1:0] vga_x;
    logic [Y_W-1:0] vga_y;
    logic [2:0]     vga_colour;
    logic           vga_plot;
    logic [15:0]    pixel_count;

    modport master (
        output start, centre_x, centre_y, radius, colour, octant_mask,
        input  done, vga_x, vga_y, vga_colour, vga_plot, pixel_count
    );

    modport slave (
        input  start, centre_x, centre_y, radius, colour, octant_mask,
        output done, vga_x, vga_y, vga_colour, vga_plot, pixel_count
    );
endinterface

// File: rtl/circle_engine.sv
// rtl/circle_engine.sv - midpoint circle rasteriser with octant mask, clipping and plot counter
module circle_engine #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int R_W      = 8
) (
    input  logic           clk,
    input  logic           rst,
    circle_engine_if.slave bus
);
    // Signed working width for coordinates; crit gets two extra bits of headroom
    localparam int W  = ((X_W > R_W) ? X_W : R_W) + 2;
    localparam int CW = W + 2;
    localparam logic signed [W-1:0] SCR_W = W'(SCREEN_W);
    localparam logic signed [W-1:0] SCR_H = W'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, INIT, PLOT, DONE} state_t;
    state_t state, state_nxt;

    // Draw parameters latched when start is accepted
    logic [X_W-1:0]       cx, cx_nxt;
    logic [Y_W-1:0]       cy, cy_nxt;
    logic [2:0]           col, col_nxt;
    logic [7:0]           mask, mask_nxt;

    // Midpoint iteration state; slot is the octant currently on the outputs
    logic signed [W-1:0]  ox, ox_nxt, oy, oy_nxt;
    logic signed [CW-1:0] crit, crit_nxt;
    logic [2:0]           slot, slot_nxt;

    // Registered outputs
    logic                 done_r, done_nxt;
    logic                 plot_r, plot_nxt;
    logic [X_W-1:0]       x_r, x_nxt;
    logic [Y_W-1:0]       y_r, y_nxt;
    logic [2:0]           vcol_r, vcol_nxt;
    logic [15:0]          count_r, count_nxt;

    // Pixel about to be presented: which slot and which (ox, oy) pair to use
    logic                 emit;
    logic [2:0]           p_slot;
    logic signed [W-1:0]  p_ox, p_oy, dx, dy, px, py;
    logic signed [W-1:0]  oy_inc, ox_dec;
    logic signed [CW-1:0] oy_inc_c, ox_dec_c;

    assign oy_inc   = oy + W'(1);
    assign ox_dec   = ox - W'(1);
    assign oy_inc_c = CW'(oy_inc);
    assign ox_dec_c = CW'(ox_dec);

    assign bus.done        = done_r;
    assign bus.vga_plot    = plot_r;
    assign bus.vga_x       = x_r;
    assign bus.vga_y       = y_r;
    assign bus.vga_colour  = vcol_r;
    assign bus.pixel_count = count_r;

    // Next-state, iteration update and next pixel selection
    always_comb begin
        state_nxt = state;
        cx_nxt    = cx;
        cy_nxt    = cy;
        col_nxt   = col;
        mask_nxt  = mask;
        ox_nxt    = ox;
        oy_nxt    = oy;
        crit_nxt  = crit;
        slot_nxt  = slot;
        done_nxt  = 1'b0;
        plot_nxt  = 1'b0;
        x_nxt     = x_r;
        y_nxt     = y_r;
        vcol_nxt  = vcol_r;
        count_nxt = count_r;
        emit      = 1'b0;
        p_slot    = 3'd0;
        p_ox      = ox;
        p_oy      = oy;

        if (plot_r && count_r != 16'hFFFF) begin
            count_nxt = count_r + 16'd1;
        end

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = INIT;
                    cx_nxt    = bus.centre_x;
                    cy_nxt    = bus.centre_y;
                    col_nxt   = bus.colour;
                    mask_nxt  = bus.octant_mask;
                    ox_nxt    = $signed({{(W-R_W){1'b0}}, bus.radius});
                    oy_nxt    = '0;
                    crit_nxt  = CW'(1) - $signed({{(CW-R_W){1'b0}}, bus.radius});
                    slot_nxt  = 3'd0;
                    count_nxt = '0;
                end
            end
            INIT: begin
                state_nxt = PLOT;
                emit      = 1'b1;
            end
            PLOT: begin
                if (slot != 3'd7) begin
                    slot_nxt = slot + 3'd1;
                    p_slot   = slot + 3'd1;
                    emit     = 1'b1;
                end else begin
                    oy_nxt = oy_inc;
                    if (crit[CW-1] || crit == '0) begin
                        crit_nxt = crit + (oy_inc_c <<< 1) + CW'(1);
                    end else begin
                        ox_nxt   = ox_dec;
                        crit_nxt = crit + ((oy_inc_c - ox_dec_c) <<< 1) + CW'(1);
                    end
                    if (oy_inc <= ox_nxt) begin
                        slot_nxt = 3'd0;
                        p_ox     = ox_nxt;
                        p_oy     = oy_inc;
                        emit     = 1'b1;
                    end else begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.start) begin
                    done_nxt = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        case (p_slot)
            3'd0:    begin dx =  p_ox; dy =  p_oy; end
            3'd1:    begin dx =  p_oy; dy =  p_ox; end
            3'd2:    begin dx = -p_oy; dy =  p_ox; end
            3'd3:    begin dx = -p_ox; dy =  p_oy; end
            3'd4:    begin dx = -p_ox; dy = -p_oy; end
            3'd5:    begin dx = -p_oy; dy = -p_ox; end
            3'd6:    begin dx =  p_oy; dy = -p_ox; end
            default: begin dx =  p_ox; dy = -p_oy; end
        endcase
        px = $signed({{(W-X_W){1'b0}}, cx}) + dx;
        py = $signed({{(W-Y_W){1'b0}}, cy}) + dy;

        if (emit) begin
            x_nxt    = px[X_W-1:0];
            y_nxt    = py[Y_W-1:0];
            vcol_nxt = col;
            plot_nxt = mask[p_slot] && !px[W-1] && (px < SCR_W)
                                    && !py[W-1] && (py < SCR_H);
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx      <= '0;
            cy      <= '0;
            col     <= '0;
            mask    <= '0;
            ox      <= '0;
            oy      <= '0;
            crit    <= '0;
            slot    <= '0;
            done_r  <= 1'b0;
            plot_r  <= 1'b0;
            x_r     <= '0;
            y_r     <= '0;
            vcol_r  <= '0;
            count_r <= '0;
        end else begin
            cx      <= cx_nxt;
            cy      <= cy_nxt;
            col     <= col_nxt;
            mask    <= mask_nxt;
            ox      <= ox_nxt;
            oy      <= oy_nxt;
            crit    <= crit_nxt;
            slot    <= slot_nxt;
            done_r  <= done_nxt;
            plot_r  <= plot_nxt;
            x_r     <= x_nxt;
            y_r     <= y_nxt;
            vcol_r  <= vcol_nxt;
            count_r <= count_nxt;
        end
    end
endmodule

// File: tb/tb_circle_engine.sv
// tb/tb_circle_engine.sv - directed self-checking bench for circle_engine
module tb_circle_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    circle_engine_if #(.X_W(8), .Y_W(7), .R_W(8)) bus ();

    circle_engine #(
        .X_W(8), .Y_W(7), .SCREEN_W(160), .SCREEN_H(120), .R_W(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int px[$], py[$], ex[$], ey[$];
    int lat;
    int n_iter;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Reference midpoint walk producing the expected plotted-pixel sequence
    task automatic model(input int cx, input int cy, input int r, input logic [7:0] m);
        int x, y, d, sx, sy;
        ex.delete();
        ey.delete();
        n_iter = 0;
        x = r;
        y = 0;
        d = 1 - r;
        do begin
            n_iter++;
            for (int s = 0; s < 8; s++) begin
                case (s)
                    0: begin sx = cx + x; sy = cy + y; end
                    1: begin sx = cx + y; sy = cy + x; end
                    2: begin sx = cx - y; sy = cy + x; end
                    3: begin sx = cx - x; sy = cy + y; end
                    4: begin sx = cx - x; sy = cy - y; end
                    5: begin sx = cx - y; sy = cy - x; end
                    6: begin sx = cx + y; sy = cy - x; end
                    default: begin sx = cx + x; sy = cy - y; end
                endcase
                if (m[s] && sx >= 0 && sx < 160 && sy >= 0 && sy < 120) begin
                    ex.push_back(sx);
                    ey.push_back(sy);
                end
            end
            y++;
            if (d <= 0) d += 2 * y + 1;
            else begin
                x--;
                d += 2 * (y - x) + 1;
            end
        end while (y <= x);
    endtask

    task automatic set_inputs(input int cx, input int cy, input int r, input logic [7:0] m);
        bus.centre_x    = 8'(cx);
        bus.centre_y    = 7'(cy);
        bus.radius      = 8'(r);
        bus.colour      = 3'd5;
        bus.octant_mask = m;
        bus.start       = 1'b1;
    endtask

    // Raise start (called at a falling edge) and capture plots until done
    task automatic draw(input int cx, input int cy, input int r, input logic [7:0] m);
        set_inputs(cx, cy, r, m);
        px.delete();
        py.delete();
        lat = -1;
        for (int k = 1; k <= 20000; k++) begin
            @(negedge clk);
            if (bus.vga_plot) begin
                px.push_back(int'(bus.vga_x));
                py.push_back(int'(bus.vga_y));
            end
            if (bus.done) begin
                lat = k - 1;
                break;
            end
        end
        if (lat < 0) check("draw_timeout", 32'd0, 32'd1);
    endtask

    task automatic compare_points(input string tag);
        int errs = 0;
        check({tag, "_nplots"}, px.size(), ex.size());
        for (int i = 0; i < px.size() && i < ex.size(); i++)
            if (px[i] != ex[i] || py[i] != ey[i]) errs++;
        check({tag, "_points"}, errs, 0);
    endtask

    task automatic release_start(input string tag);
        bus.start = 1'b0;
        @(negedge clk);
        check({tag, "_done_drop"}, 32'(bus.done), 0);
    endtask

    initial begin
        int viol, dcnt, first;
        bus.start       = 1'b0;
        bus.centre_x    = '0;
        bus.centre_y    = '0;
        bus.radius      = '0;
        bus.colour      = '0;
        bus.octant_mask = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_done", 32'(bus.done), 0);
        check("rst_plot", 32'(bus.vga_plot), 0);
        check("rst_count", 32'(bus.pixel_count), 0);
        check("rst_x", 32'(bus.vga_x), 0);
        check("rst_y", 32'(bus.vga_y), 0);
        check("rst_colour", 32'(bus.vga_colour), 0);
        rst = 1'b0;
        @(negedge clk);

        // radius 0: eight plots of the centre, done after 9 edges
        model(80, 60, 0, 8'hFF);
        draw(80, 60, 0, 8'hFF);
        check("r0_lat", lat, 9);
        check("r0_count", 32'(bus.pixel_count), 8);
        check("r0_colour", 32'(bus.vga_colour), 5);
        compare_points("r0");
        repeat (3) @(negedge clk);
        check("r0_done_held", 32'(bus.done), 1);
        release_start("r0");

        // radius 1: two iterations
        model(80, 60, 1, 8'hFF);
        draw(80, 60, 1, 8'hFF);
        check("r1_lat", lat, 17);
        check("r1_count", 32'(bus.pixel_count), 16);
        compare_points("r1");
        if (px.size() >= 9) begin
            check("r1_s0_x", px[0], 81); check("r1_s0_y", py[0], 60);
            check("r1_s1_x", px[1], 80); check("r1_s1_y", py[1], 61);
            check("r1_s2_x", px[2], 80); check("r1_s2_y", py[2], 61);
            check("r1_s3_x", px[3], 79); check("r1_s3_y", py[3], 60);
            check("r1_i2_x", px[8], 81); check("r1_i2_y", py[8], 61);
        end else check("r1_size", px.size(), 16);
        release_start("r1");

        // radius 40: timing, count and closeness to the true circle
        model(80, 60, 40, 8'hFF);
        draw(80, 60, 40, 8'hFF);
        check("r40_lat", lat, 8 * n_iter + 1);
        check("r40_count", 32'(bus.pixel_count), 8 * n_iter);
        compare_points("r40");
        viol = 0;
        for (int i = 0; i < px.size(); i++) begin
            int e;
            e = (px[i] - 80) * (px[i] - 80) + (py[i] - 60) * (py[i] - 60) - 1600;
            if (e > 80 || e < -80) viol++;
        end
        check("r40_on_circle", viol, 0);
        release_start("r40");

        // Clipping near the top-left corner
        model(5, 5, 20, 8'hFF);
        draw(5, 5, 20, 8'hFF);
        check("clip_lat", lat, 8 * n_iter + 1);
        check("clip_count", 32'(bus.pixel_count), ex.size());
        check("clip_fewer", 32'(int'(bus.pixel_count) < 8 * n_iter), 1);
        compare_points("clip");
        viol = 0;
        for (int i = 0; i < px.size(); i++)
            if (px[i] >= 160 || py[i] >= 120) viol++;
        check("clip_offscreen", viol, 0);
        release_start("clip");

        // Single-octant mask
        model(80, 60, 10, 8'h01);
        draw(80, 60, 10, 8'h01);
        check("mask_lat", lat, 8 * n_iter + 1);
        check("mask_count", 32'(bus.pixel_count), n_iter);
        compare_points("mask");
        viol = 0;
        for (int i = 0; i < px.size(); i++)
            if (px[i] < 80 || py[i] < 60 || (px[i] - 80) < (py[i] - 60)) viol++;
        check("mask_octant", viol, 0);
        release_start("mask");

        // start dropped right after acceptance: draw completes, done pulses once
        set_inputs(80, 60, 1, 8'hFF);
        @(negedge clk);
        bus.start = 1'b0;
        dcnt  = 0;
        first = -1;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                dcnt++;
                if (first < 0) first = k - 1;
            end
        end
        check("drop_done_edge", first, 17);
        check("drop_done_cycles", dcnt, 1);

        // Reset at slot 3 of iteration 5, then a fresh draw with start held
        model(80, 60, 40, 8'hFF);
        set_inputs(80, 60, 40, 8'hFF);
        repeat (37) @(negedge clk);
        check("pre_rst_count", 32'(bus.pixel_count), 35);
        check("pre_rst_plot", 32'(bus.vga_plot), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_plot", 32'(bus.vga_plot), 0);
        check("mid_rst_done", 32'(bus.done), 0);
        check("mid_rst_count", 32'(bus.pixel_count), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        draw(80, 60, 40, 8'hFF);
        check("post_rst_lat", lat, 8 * n_iter + 1);
        check("post_rst_count", 32'(bus.pixel_count), 8 * n_iter);
        compare_points("post_rst");
        release_start("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/circle_engine.md
Name: circle_engine

Overview:
- Parametrised successor to the fixed 160x120 circle drawer.
- Rasterises a circle outline with the midpoint (Bresenham) algorithm and streams one pixel per cycle to the vga_adapter x/y/colour/plot interface.
- Adds generic screen dimensions, a runtime octant mask for arcs and partial circles, off-screen clipping, and a plotted-pixel counter.
- Sits between the top-level control FSM and vga_adapter, alongside the fillscreen and Reuleaux-triangle blocks.

Parameters:
X_W, 8, width of x coordinates (vga_x, centre_x)
Y_W, 7, width of y coordinates (vga_y, centre_y)
SCREEN_W, 160, visible width in pixels; x >= SCREEN_W is clipped
SCREEN_H, 120, visible height in pixels; y >= SCREEN_H is clipped
R_W, 8, width of radius

Ports:
clk  in  1  system clock (CLOCK_50 domain)
rst  in  1  asynchronous, active-high reset
start  in  1  level request; held high until done is seen
centre_x  in  X_W  circle centre x
centre_y  in  Y_W  circle centre y
radius  in  R_W  circle radius
colour  in  3  pixel colour
octant_mask  in  8  bit k=1 enables octant slot k
done  out  1  drawing complete
vga_x  out  X_W  pixel x
vga_y  out  Y_W  pixel y
vga_colour  out  3  pixel colour
vga_plot  out  1  write strobe for vga_adapter
pixel_count  out  16  number of vga_plot pulses in the current or last draw

Behaviour:
- Reset: async; forces state IDLE. done, vga_plot and pixel_count go to 0; vga_x, vga_y and vga_colour go to 0. Reset mid-draw aborts immediately with no further plots.
- All outputs are registered.
- States: IDLE, INIT, PLOT, DONE.
- IDLE: start=1 at a rising edge moves to INIT.
- INIT (1 cycle):
  - Latch centre, radius, colour and octant_mask. Input changes after this cycle are ignored until the next draw.
  - Set ox=radius, oy=0, crit=1-radius, slot=0, pixel_count=0.
- PLOT: one cycle per slot, slot 0..7 in this order:
  - slot 0: (cx+ox, cy+oy)
  - slot 1: (cx+oy, cy+ox)
  - slot 2: (cx-oy, cy+ox)
  - slot 3: (cx-ox, cy+oy)
  - slot 4: (cx-ox, cy-oy)
  - slot 5: (cx-oy, cy-ox)
  - slot 6: (cx+oy, cy-ox)
  - slot 7: (cx+ox, cy-oy)
- Per-slot output:
  - vga_x, vga_y and vga_colour present the slot coordinate and latched colour.
  - vga_plot=1 only if octant_mask[slot]=1 and the coordinate is on-screen.
  - Masked and clipped slots still consume their cycle, with vga_plot=0.
- Arithmetic width: coordinates are computed signed at max(X_W,R_W)+2 bits. Clip if x<0, x>=SCREEN_W, y<0 or y>=SCREEN_H. vga_x and vga_y carry the low bits of the coordinate even when clipped.
- pixel_count increments on every vga_plot=1 cycle and saturates at 16'hFFFF.
- After slot 7, update the iteration:
  - oy <= oy+1.
  - If crit<=0: crit += 2*(oy+1)+1.
  - Else: ox <= ox-1 and crit += 2*((oy+1)-(ox-1))+1.
  - If the new oy <= new ox, return to slot 0; otherwise go to DONE.
- Latency: with N loop iterations, done rises exactly 8N+1 rising edges after the edge that accepted start. vga_plot is low in IDLE, INIT and DONE.
- DONE:
  - done=1 and is held while start=1.
  - When start=0, go to IDLE and done drops on the next edge.
  - If start was dropped mid-draw, the draw still completes; done is then high for exactly one cycle.
  - A new draw needs start low-then-high, or start still high one cycle after returning to IDLE.
- Duplicate pixels are legal and counted: diagonal points and the radius=0 case, where all 8 slots hit the centre.
- radius=0: N=1; all 8 slots plot the centre (subject to mask and clip); done after 9 edges.

Test Plan:
- Centre (80,60), radius=0, mask=8'hFF, start held: 8 plots at (80,60); done high after 9 edges; pixel_count=8; done held until start drops, then IDLE.
- Centre (80,60), r=1, mask=8'hFF:
  - N=2, done after 17 edges, pixel_count=16.
  - Iteration 1, slots 0-3: (81,60), (80,61), (80,61), (79,60).
  - Iteration 2, slot 0: (81,61).
- Centre (80,60), r=40, mask=8'hFF: every plotted (x,y) satisfies |(x-80)^2+(y-60)^2-1600| <= 80; cycle count and pixel_count match a reference midpoint model (pixel_count = 8N).
- Clipping: centre (5,5), r=20, mask=8'hFF: no plot with x>=160 or y>=120, and no wrapped coordinate near 255/127; pixel_count is below 8N.
- Octant mask 8'b0000_0001, centre (80,60), r=10: plots only slot-0 points, i.e. x>=80, y>=60, x-80>=y-60; timing identical to the full-mask run.
- rst pulsed mid-draw at slot 3 of iteration 5: vga_plot and done are 0 immediately; after release with start high, a fresh draw starts with pixel_count reset to 0.
